// File: rtl/ysyx_23060201_idu_stage.sv
// rtl/ysyx_23060201_idu_stage.sv - buffered RV32/RV64 instruction-decode stage
// Decodes on the input side and queues decoded entries in an in-order FIFO.
module ysyx_23060201_idu_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_imm,
    output logic [6:0]      out_op,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_func3,
    output logic [6:0]      out_func7,
    output logic [1:0]      out_ren,
    output logic            out_wen,
    output logic            out_illegal,
    output logic            out_trap,
    output logic [CW-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] imm;
        logic [2:0]      func3;
        logic [1:0]      ren;
        logic            wen;
        logic            illegal;
        logic            trap;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    entry_t          w_dec;
    entry_t          w_head;
    logic            w_wen_raw;
    logic            w_push;
    logic            w_pop;
    logic [6:0]      w_op;

    assign w_op = in_inst[6:0];

    always_comb begin
        w_dec         = '0;
        w_wen_raw     = 1'b0;
        w_dec.pc      = in_pc;
        w_dec.inst    = in_inst;
        w_dec.trap    = (in_inst == 32'h0010_0073);
        w_dec.func3   = in_inst[14:12];
        case (w_op)
            7'b0110011: begin w_dec.ren = 2'b11; w_wen_raw = 1'b1; end
            7'b0010011,
            7'b0000011,
            7'b1100111: begin
                w_dec.ren = 2'b01; w_wen_raw = 1'b1;
                w_dec.imm = XLEN'($signed(in_inst[31:20]));
            end
            7'b0100011: begin
                w_dec.ren = 2'b11;
                w_dec.imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            end
            7'b1100011: begin
                w_dec.ren = 2'b11;
                w_dec.imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                           in_inst[11:8], 1'b0}));
            end
            7'b0110111,
            7'b0010111: begin
                w_wen_raw = 1'b1;
                w_dec.imm = XLEN'($signed({in_inst[31:12], 12'b0}));
            end
            7'b1101111: begin
                w_wen_raw = 1'b1;
                w_dec.imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                           in_inst[30:21], 1'b0}));
            end
            7'b1110011: w_dec.imm = XLEN'($signed(in_inst[31:20]));
            // Word-sized RV64 ops fall through to illegal on RV32 builds
            7'b0011011: begin
                if (XLEN == 64) begin
                    w_dec.ren = 2'b01; w_wen_raw = 1'b1;
                    w_dec.imm = XLEN'($signed(in_inst[31:20]));
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            7'b0111011: begin
                if (XLEN == 64) begin
                    w_dec.ren = 2'b11; w_wen_raw = 1'b1;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            default: w_dec.illegal = 1'b1;
        endcase
        w_dec.wen = w_wen_raw && (in_inst[11:7] != 5'd0);
        if (w_op == 7'b0010111 || w_op == 7'b1101111) begin
            w_dec.func3 = 3'b000;
        end
    end

    assign in_ready  = (r_count < FULL) && !flush;
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready && !flush;
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_head = '0;
        if (out_valid) begin
            w_head = r_mem[r_rptr];
        end
    end

    assign out_pc      = w_head.pc;
    assign out_inst    = w_head.inst;
    assign out_imm     = w_head.imm;
    assign out_op      = w_head.inst[6:0];
    assign out_rd      = w_head.inst[11:7];
    assign out_rs1     = w_head.inst[19:15];
    assign out_rs2     = w_head.inst[24:20];
    assign out_func3   = w_head.func3;
    assign out_func7   = w_head.inst[31:25];
    assign out_ren     = w_head.ren;
    assign out_wen     = w_head.wen;
    assign out_illegal = w_head.illegal;
    assign out_trap    = w_head.trap;
endmodule

// File: tb/tb_ysyx_23060201_idu_stage.sv
// tb/tb_ysyx_23060201_idu_stage.sv - scoreboard bench for the decode stage
module tb_ysyx_23060201_idu_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  func3;
        logic [1:0]  ren;
        logic        wen;
        logic        illegal;
        logic        trap;
    } exp_t;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    // RV32 instance, scoreboarded
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_pc, out_inst, out_imm;
    logic [6:0]  out_op, out_func7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_func3, count;
    logic [1:0]  out_ren;
    logic        out_wen, out_illegal, out_trap;

    ysyx_23060201_idu_stage #(.XLEN(32), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_imm(out_imm), .out_op(out_op),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_func3(out_func3),
        .out_func7(out_func7), .out_ren(out_ren), .out_wen(out_wen),
        .out_illegal(out_illegal), .out_trap(out_trap), .count(count));

    // RV64 instance, directed checks only
    logic        v_valid, v_ready, v_ovalid;
    logic [31:0] v_inst, v_oinst;
    logic [63:0] v_pc, v_opc, v_imm;
    logic [6:0]  v_op, v_func7;
    logic [4:0]  v_rd, v_rs1, v_rs2;
    logic [2:0]  v_func3, v_count;
    logic [1:0]  v_ren;
    logic        v_wen, v_illegal, v_trap;

    ysyx_23060201_idu_stage #(.XLEN(64), .DEPTH(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(v_valid), .in_ready(v_ready),
        .in_inst(v_inst), .in_pc(v_pc), .out_valid(v_ovalid), .out_ready(1'b1),
        .out_pc(v_opc), .out_inst(v_oinst), .out_imm(v_imm), .out_op(v_op),
        .out_rd(v_rd), .out_rs1(v_rs1), .out_rs2(v_rs2), .out_func3(v_func3),
        .out_func7(v_func7), .out_ren(v_ren), .out_wen(v_wen),
        .out_illegal(v_illegal), .out_trap(v_trap), .count(v_count));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] inst, input logic [63:0] pc, input bit rv64);
        exp_t e;
        logic signed [63:0] s;
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        logic signed [31:0] u32;
        e = '{pc: pc, inst: inst, imm: 64'd0, func3: inst[14:12], ren: 2'b00,
              wen: 1'b0, illegal: 1'b0, trap: (inst == 32'h0010_0073)};
        i12 = inst[31:20];
        b13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        j21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        u32 = {inst[31:12], 12'h000};
        s = 64'sd0;
        unique case (inst[6:0])
            7'h33: begin e.ren = 2'b11; e.wen = 1'b1; end
            7'h13, 7'h03, 7'h67: begin e.ren = 2'b01; e.wen = 1'b1; s = i12; end
            7'h23: begin e.ren = 2'b11; s = 12'(signed'({inst[31:25], inst[11:7]})); end
            7'h63: begin e.ren = 2'b11; s = b13; end
            7'h37: begin e.wen = 1'b1; s = u32; end
            7'h17: begin e.wen = 1'b1; s = u32; e.func3 = 3'd0; end
            7'h6f: begin e.wen = 1'b1; s = j21; e.func3 = 3'd0; end
            7'h73: s = i12;
            7'h1b: if (rv64) begin e.ren = 2'b01; e.wen = 1'b1; s = i12; end else e.illegal = 1'b1;
            7'h3b: if (rv64) begin e.ren = 2'b11; e.wen = 1'b1; end else e.illegal = 1'b1;
            default: e.illegal = 1'b1;
        endcase
        if (inst[11:7] == 5'd0) e.wen = 1'b0;
        e.imm = s;
        return e;
    endfunction

    // Scoreboard: compares the head every cycle, pushes/pops on the modelled handshake
    always @(negedge clk) begin
        bit exp_ready, exp_valid;
        exp_t h;
        if (!rst_n) begin
            q.delete();
        end else begin
            exp_ready = (q.size() < 4) && !flush;
            exp_valid = (q.size() != 0);
            chk("count", 64'(count), 64'(q.size()));
            chk("in_ready", 64'(in_ready), 64'(exp_ready));
            chk("out_valid", 64'(out_valid), 64'(exp_valid));
            if (exp_valid) begin
                h = q[0];
                chk("head_pc", 64'(out_pc), h.pc);
                chk("head_inst", 64'(out_inst), 64'(h.inst));
                chk("head_imm", 64'(out_imm), 64'(h.imm[31:0]));
                chk("head_ren", 64'(out_ren), 64'(h.ren));
                chk("head_wen", 64'(out_wen), 64'(h.wen));
                chk("head_illegal", 64'(out_illegal), 64'(h.illegal));
                chk("head_trap", 64'(out_trap), 64'(h.trap));
                chk("head_func3", 64'(out_func3), 64'(h.func3));
                chk("head_rd", 64'(out_rd), 64'(h.inst[11:7]));
            end else begin
                chk("idle_pc", 64'(out_pc), 64'd0);
                chk("idle_imm", 64'(out_imm), 64'd0);
                chk("idle_inst", 64'(out_inst), 64'd0);
            end
            if (flush) begin
                q.delete();
            end else begin
                if (exp_valid && out_ready) void'(q.pop_front());
                if (in_valid && exp_ready) q.push_back(model(in_inst, 64'(in_pc), 1'b0));
            end
        end
    end

    logic [6:0] ops [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37,
                             7'h17, 7'h6f, 7'h67, 7'h73, 7'h1b, 7'h7f};
    logic [31:0] pc_ctr = 32'h8000_0000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand();
        logic [31:0] r;
        r = $urandom();
        in_inst = {r[31:7], ops[$urandom_range(0, 11)]};
        in_pc   = pc_ctr;
        pc_ctr  = pc_ctr + 32'd4;
    endtask

    task automatic push_one(input logic [31:0] inst);
        in_inst = inst; in_pc = pc_ctr; pc_ctr = pc_ctr + 32'd4;
        in_valid = 1'b1; step(); in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic push64(input logic [31:0] inst);
        v_inst = inst; v_pc = 64'h0000_0001_0000_0000;
        v_valid = 1'b1; step(); v_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0; v_valid = 1'b0; v_inst = '0; v_pc = '0;
        step(); step();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_imm", 64'(out_imm), 64'd0);
        rst_n = 1'b1; step();

        // addi x1,x0,5 at the reset PC
        pc_ctr = 32'h8000_0000;
        push_one(32'h0050_0093);
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_pc", 64'(out_pc), 64'h8000_0000);
        chk("addi_imm", 64'(out_imm), 64'd5);
        chk("addi_rd", 64'(out_rd), 64'd1);
        chk("addi_ren", 64'(out_ren), 64'd1);
        chk("addi_wen", 64'(out_wen), 64'd1);
        chk("addi_func3", 64'(out_func3), 64'd0);
        chk("addi_count", 64'(count), 64'd1);
        pop_one();

        // Fill past full with the consumer stalled, then drain
        for (int i = 0; i < 5; i++) begin
            drive_rand(); in_valid = 1'b1; step();
        end
        in_valid = 1'b0;
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1; step();
        chk("after_pop_ready", 64'(in_ready), 64'd1);
        step(); step(); step();
        out_ready = 1'b0;
        chk("drained_count", 64'(count), 64'd0);

        // Concurrent push/pop at count 2 across several pointer wraps
        push_one(32'h0020_8113); push_one(32'h0031_01b3);
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_rand(); step();
            chk("steady_count", 64'(count), 64'd2);
        end
        in_valid = 1'b0;

        // Flush with an offered instruction at count 3
        out_ready = 1'b0;
        push_one(32'h0000_0013);
        chk("pre_flush_count", 64'(count), 64'd3);
        flush = 1'b1; in_valid = 1'b1; drive_rand(); out_ready = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("post_flush_count", 64'(count), 64'd0);
        chk("post_flush_valid", 64'(out_valid), 64'd0);

        // Decode edge cases on RV32
        push_one(32'h0010_0073);
        chk("ebreak_trap", 64'(out_trap), 64'd1);
        chk("ebreak_ren", 64'(out_ren), 64'd0);
        chk("ebreak_wen", 64'(out_wen), 64'd0);
        pop_one();
        push_one(32'hFE00_0EE3);
        chk("beq_imm", 64'(out_imm), 64'hFFFF_FFFC);
        chk("beq_ren", 64'(out_ren), 64'd3);
        chk("beq_wen", 64'(out_wen), 64'd0);
        pop_one();
        push_one(32'h0000_006F);
        chk("jal_wen", 64'(out_wen), 64'd0);
        chk("jal_func3", 64'(out_func3), 64'd0);
        pop_one();
        push_one(32'h0010_809B);
        chk("addiw32_illegal", 64'(out_illegal), 64'd1);
        chk("addiw32_ren", 64'(out_ren), 64'd0);
        chk("addiw32_wen", 64'(out_wen), 64'd0);
        pop_one();

        // RV64 decode
        push64(32'h8000_0137);
        chk("lui64_imm", v_imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui64_rd", 64'(v_rd), 64'd2);
        step();
        push64(32'h0010_809B);
        chk("addiw64_illegal", 64'(v_illegal), 64'd0);
        chk("addiw64_ren", 64'(v_ren), 64'd1);
        chk("addiw64_imm", v_imm, 64'd1);
        chk("addiw64_wen", 64'(v_wen), 64'd1);
        step();
        push64(32'hFE00_0EE3);
        chk("beq64_imm", v_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        step();

        // Asynchronous reset in the middle of a non-empty queue
        push_one(32'h0050_0093); push_one(32'h0060_0113);
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_pc", 64'(out_pc), 64'd0);
        step();
        rst_n = 1'b1;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
